clk_period_monitor: RTL and testbench

Receive-side companion to the team's clock divider. It takes a slow, asynchronous clock (the divided ~100 kHz clock, or any slow camera-side clock) into the `ref_clk` domain. It measures each period in `ref_clk` cycles, checks the period against a tolerance window, and reports lock and loss status. The block sits in the camera subsystem as a health check in front of any logic that depends on the slow clock.

---
 rtl/clk_period_monitor.sv | 141 ++++++++++++++
 tb/tb_clk_period_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Brings a slow asynchronous clock into the ref_clk domain, measures each of
//   its periods in ref_clk cycles, checks the measured period against a
//   tolerance window, and reports lock and loss of the monitored clock.
//
// Ports
//   ref_clk       in   system clock; the only clock in the block
//   reset         in   asynchronous active-high reset
//   clk_in        in   monitored slow clock, asynchronous to ref_clk
//   rise_pulse    out  one-cycle strobe per detected rising edge of clk_in
//   period        out  [CNT_W] most recent measured period, held between updates
//   period_valid  out  one-cycle strobe when period has just been updated
//   locked        out  high while in LOCKED
//   lost          out  high while in LOST
module clk_period_monitor #(
  parameter int CNT_W      = 12,
  parameter int MIN_PERIOD = 990,
  parameter int MAX_PERIOD = 1010,
  parameter int TIMEOUT    = 2000,
  parameter int LOCK_COUNT = 4
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GC_W-1:0]  LC_C    = GC_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  state_t           state, state_n;
  logic [GC_W-1:0]  good_cnt, good_n;
  logic [CNT_W-1:0] cnt;
  logic             sync1, sync2, sync3;
  logic             rise, report, in_range;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= clk_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

  // Loading 1 on the edge makes cnt equal the edge-to-edge distance when the
  // next edge arrives. Saturation keeps a dead clock from wrapping back into
  // the tolerance window.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (rise)             cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX)   cnt <= cnt + 1'b1;
  end

  assign in_range = (cnt >= MIN_C) && (cnt <= MAX_C);

  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_n;
    end
  end

  // An edge always takes priority over the timeout on the same cycle.
  always_comb begin
    state_n = state;
    good_n  = good_cnt;
    report  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end else if (cnt == TO_C) begin
          state_n = LOST;
        end
      end
      ACQUIRE, LOCKED: begin
        if (rise) begin
          report = 1'b1;
          if (in_range) begin
            good_n = (good_cnt == LC_C) ? good_cnt : good_cnt + 1'b1;
            if (good_n == LC_C) state_n = LOCKED;
          end else begin
            good_n  = '0;
            state_n = ACQUIRE;
          end
        end else if (cnt == TO_C) begin
          state_n = LOST;
        end
      end
      LOST: begin
        // Re-arm only: no prior edge to measure against.
        if (rise) begin
          state_n = ACQUIRE;
          good_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status flags are registered from the next state so locked/lost change
  // in the same cycle as the period_valid that caused them.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      rise_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      rise_pulse   <= rise;
      period_valid <= report;
      if (report) period <= cnt;
      locked       <= (state_n == LOCKED);
      lost         <= (state_n == LOST);
    end
  end

endmodule

// File: tb/tb_clk_period_monitor.sv
module tb_clk_period_monitor;
  localparam int CNT_W = 12;
  localparam int MINP  = 990;
  localparam int MAXP  = 1010;
  localparam int TO    = 2000;
  localparam int LC    = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             ref_clk = 1'b0;
  logic             reset;
  logic             clk_in = 1'b0;
  logic             rise_pulse, period_valid, locked, lost;
  logic [CNT_W-1:0] period;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ref_clk = ~ref_clk;

  clk_period_monitor #(.CNT_W(CNT_W), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP),
                       .TIMEOUT(TO), .LOCK_COUNT(LC)) dut (
    .ref_clk(ref_clk), .reset(reset), .clk_in(clk_in),
    .rise_pulse(rise_pulse), .period(period), .period_valid(period_valid),
    .locked(locked), .lost(lost)
  );

  // Reference model: tracks edge times in ref_clk cycles. A clk_in level first
  // seen high at edge N takes effect at edge N+2; period is the time between
  // effective edges.
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mstate_t;
  mstate_t          ms;
  int               cyc, last_rise, good;
  bit               prev_in;
  int               rise_q[$];
  logic             m_rp, m_pv, m_locked, m_lost;
  logic [CNT_W-1:0] m_period;

  always @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      ms = M_IDLE; cyc = 0; last_rise = 1; good = 0; prev_in = 0;
      rise_q.delete();
      m_rp = 0; m_pv = 0; m_locked = 0; m_lost = 0; m_period = '0;
    end else begin : mdl
      int el;
      bit r;
      cyc++;
      r = (rise_q.size() > 0 && rise_q[0] == cyc);
      if (r) void'(rise_q.pop_front());
      if (clk_in && !prev_in) rise_q.push_back(cyc + 2);
      prev_in = clk_in;
      el = cyc - last_rise;
      if (el > SAT) el = SAT;
      m_rp = r;
      m_pv = 0;
      if (r) begin
        last_rise = cyc;
        if (ms == M_IDLE || ms == M_LOST) begin
          ms = M_ACQ; good = 0;
        end else begin
          m_pv = 1;
          m_period = el[CNT_W-1:0];
          if (el >= MINP && el <= MAXP) begin
            if (good < LC) good++;
            if (good >= LC) ms = M_LOCK;
          end else begin
            good = 0; ms = M_ACQ;
          end
        end
      end else if (ms != M_LOST && el == TO) begin
        ms = M_LOST;
      end
      m_locked = (ms == M_LOCK);
      m_lost   = (ms == M_LOST);
    end
  end

  // Monitor: model divergence tally and event counters read by the tests.
  int    mism = 0;
  string first_mm = "";
  int    pv_count = 0, rp_count = 0, since_rp = 0;
  logic  pv_locked_q[$];

  always @(negedge ref_clk) begin
    if ({rise_pulse, period_valid, locked, lost, period} !==
        {m_rp, m_pv, m_locked, m_lost, m_period}) begin
      mism++;
      if (first_mm == "")
        first_mm = $sformatf("t=%0t dut rp=%b pv=%b lk=%b ls=%b per=%0d / model rp=%b pv=%b lk=%b ls=%b per=%0d",
                             $time, rise_pulse, period_valid, locked, lost, period,
                             m_rp, m_pv, m_locked, m_lost, m_period);
    end
    if (period_valid) begin
      pv_count++;
      pv_locked_q.push_back(locked);
    end
    if (rise_pulse) begin
      rp_count++;
      since_rp = 0;
    end else begin
      since_rp++;
    end
  end

  // One clk_in period of hi+lo ref_clk cycles, rising edge first.
  task automatic gen(input int hi, input int lo);
    @(negedge ref_clk); clk_in = 1'b1;
    repeat (hi) @(negedge ref_clk);
    clk_in = 1'b0;
    repeat (lo - 1) @(negedge ref_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge ref_clk);
    #1;
    n_checks++; if (rise_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_rp: got %b want 0", rise_pulse); end
    n_checks++; if (period !== '0)         begin n_fail++; $display("FAIL reset_period: got %0d want 0", period); end
    n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv: got %b want 0", period_valid); end
    n_checks++; if (locked !== 1'b0)       begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (lost !== 1'b0)         begin n_fail++; $display("FAIL reset_lost: got %b want 0", lost); end
    @(negedge ref_clk); reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    int pv0, rp0, m0;
    pv0 = pv_count; rp0 = rp_count; m0 = mism;
    pv_locked_q.delete();
    gen(500, 500);
    n_checks++; if (rp_count - rp0 !== 1) begin n_fail++; $display("FAIL clean_first_rp: got %0d want 1", rp_count - rp0); end
    n_checks++; if (pv_count - pv0 !== 0) begin n_fail++; $display("FAIL clean_first_pv: got %0d want 0", pv_count - pv0); end
    for (int i = 0; i < 4; i++) begin
      int h;
      h = $urandom_range(100, 900);
      gen(h, 1000 - h);
    end
    n_checks++; if (pv_count - pv0 !== 4) begin n_fail++; $display("FAIL clean_pv_count: got %0d want 4", pv_count - pv0); end
    n_checks++; if (period !== 12'd1000)  begin n_fail++; $display("FAIL clean_period: got %0d want 1000", period); end
    n_checks++; if (locked !== 1'b1)      begin n_fail++; $display("FAIL clean_locked: got %b want 1", locked); end
    n_checks++; if (lost !== 1'b0)        begin n_fail++; $display("FAIL clean_lost: got %b want 0", lost); end
    n_checks++;
    if (pv_locked_q.size() != 4 || pv_locked_q[2] !== 1'b0 || pv_locked_q[3] !== 1'b1) begin
      n_fail++; $display("FAIL clean_lock_timing: pv seen %0d, lock at 3rd/4th pv not 0/1", pv_locked_q.size());
    end
    n_checks++; if (mism - m0 !== 0) begin n_fail++; $display("FAIL clean_model: %0d diffs, first %s", mism - m0, first_mm); end
  endtask

  task automatic test_tolerance();
    int m0;
    m0 = mism;
    gen(495, 495);
    gen(505, 505);
    n_checks++; if (period !== 12'd990 || locked !== 1'b1) begin n_fail++; $display("FAIL tol_990: got per=%0d lk=%b want 990/1", period, locked); end
    gen(505, 506);
    n_checks++; if (period !== 12'd1010 || locked !== 1'b1) begin n_fail++; $display("FAIL tol_1010: got per=%0d lk=%b want 1010/1", period, locked); end
    gen(500, 500);
    n_checks++; if (period !== 12'd1011 || locked !== 1'b0) begin n_fail++; $display("FAIL tol_1011: got per=%0d lk=%b want 1011/0", period, locked); end
    n_checks++; if (pv_locked_q[$] !== 1'b0) begin n_fail++; $display("FAIL tol_drop_cycle: locked at bad pv=%b want 0", pv_locked_q[$]); end
    repeat (3) gen(500, 500);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL tol_relock_early: got %b want 0", locked); end
    gen(500, 500);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL tol_relock: got %b want 1", locked); end
    n_checks++; if (mism - m0 !== 0) begin n_fail++; $display("FAIL tol_model: %0d diffs, first %s", mism - m0, first_mm); end
  endtask

  task automatic test_clock_stop();
    int pv0, rp0, m0;
    m0 = mism;
    for (int i = 0; i < 3000 && lost !== 1'b1; i++) begin
      @(negedge ref_clk); #1;
    end
    n_checks++; if (lost !== 1'b1)   begin n_fail++; $display("FAIL stop_lost: got %b want 1 (bound expired)", lost); end
    n_checks++; if (since_rp !== TO) begin n_fail++; $display("FAIL stop_lost_time: got %0d cycles want %0d", since_rp, TO); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stop_locked: got %b want 0", locked); end
    repeat (2500) @(negedge ref_clk);
    #1;
    n_checks++; if (lost !== 1'b1) begin n_fail++; $display("FAIL stop_lost_held: got %b want 1", lost); end
    pv0 = pv_count; rp0 = rp_count;
    gen(500, 500);
    n_checks++; if (pv_count - pv0 !== 0 || rp_count - rp0 !== 1) begin n_fail++; $display("FAIL stop_rearm: got pv=%0d rp=%0d want 0/1", pv_count - pv0, rp_count - rp0); end
    n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL stop_lost_clear: got %b want 0", lost); end
    repeat (4) gen(500, 500);
    n_checks++; if (locked !== 1'b1 || pv_count - pv0 !== 4) begin n_fail++; $display("FAIL stop_relock: got lk=%b pv=%0d want 1/4", locked, pv_count - pv0); end
    n_checks++; if (mism - m0 !== 0) begin n_fail++; $display("FAIL stop_model: %0d diffs, first %s", mism - m0, first_mm); end
  endtask

  task automatic test_no_clock();
    int pv0;
    @(negedge ref_clk); reset = 1'b1; clk_in = 1'b0;
    repeat (3) @(negedge ref_clk);
    reset = 1'b0;
    pv0 = pv_count;
    repeat (TO) @(negedge ref_clk);
    #1;
    n_checks++; if (lost !== 1'b0) begin n_fail++; $display("FAIL noclk_early: got %b want 0", lost); end
    @(negedge ref_clk); #1;
    n_checks++; if (lost !== 1'b1)  begin n_fail++; $display("FAIL noclk_lost: got %b want 1", lost); end
    n_checks++; if (period !== '0 || pv_count - pv0 !== 0) begin n_fail++; $display("FAIL noclk_period: got per=%0d pv=%0d want 0/0", period, pv_count - pv0); end
  endtask

  task automatic test_collision();
    int pv0, m0;
    m0 = mism;
    gen(1000, 1000);
    pv0 = pv_count;
    @(negedge ref_clk); clk_in = 1'b1;
    repeat (5) @(negedge ref_clk);
    #1;
    n_checks++; if (period !== 12'd2000 || pv_count - pv0 !== 1) begin n_fail++; $display("FAIL coll_period: got per=%0d pv=%0d want 2000/1", period, pv_count - pv0); end
    n_checks++; if (lost !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL coll_state: got ls=%b lk=%b want 0/0", lost, locked); end
    clk_in = 1'b0;
    repeat (3) @(negedge ref_clk);
    #1;
    n_checks++; if (mism - m0 !== 0) begin n_fail++; $display("FAIL coll_model: %0d diffs, first %s", mism - m0, first_mm); end
  endtask

  task automatic test_async_reset();
    int pv0, rp0;
    repeat (5) gen(500, 500);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL areset_prelock: got %b want 1", locked); end
    repeat (100) @(negedge ref_clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({rise_pulse, period_valid, locked, lost} !== 4'b0 || period !== '0) begin
      n_fail++; $display("FAIL areset_outputs: got rp=%b pv=%b lk=%b ls=%b per=%0d want all 0",
                         rise_pulse, period_valid, locked, lost, period);
    end
    repeat (3) @(negedge ref_clk);
    reset = 1'b0;
    pv0 = pv_count; rp0 = rp_count;
    gen(500, 500);
    n_checks++; if (pv_count - pv0 !== 0 || rp_count - rp0 !== 1) begin n_fail++; $display("FAIL areset_arm: got pv=%0d rp=%0d want 0/1", pv_count - pv0, rp_count - rp0); end
    gen(500, 500);
    n_checks++; if (pv_count - pv0 !== 1 || period !== 12'd1000) begin n_fail++; $display("FAIL areset_first: got pv=%0d per=%0d want 1/1000", pv_count - pv0, period); end
  endtask

  task automatic test_random();
    int pv0, m0, p, h;
    pv0 = pv_count; m0 = mism;
    for (int i = 0; i < 20; i++) begin
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1100) : $urandom_range(985, 1015);
      h = $urandom_range(2, p - 2);
      gen(h, p - h);
    end
    n_checks++; if (pv_count - pv0 !== 20) begin n_fail++; $display("FAIL rand_pv_count: got %0d want 20", pv_count - pv0); end
    n_checks++; if (mism - m0 !== 0) begin n_fail++; $display("FAIL rand_model: %0d diffs, first %s", mism - m0, first_mm); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_tolerance();
    test_clock_stop();
    test_no_clock();
    test_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
